dfm_meas_sequencer: RTL
=======================

Name: dfm_meas_sequencer

Overview:
- Sequencer for the equal-precision frequency/period measurement path.
- Generates the preset gate and the signal-synchronised real gate, and runs the standard-clock and signal-edge counters under that gate.
- Latches one result per measurement and hands it to the UART reporting logic over a valid/ready handshake.
- Single clock domain: the measured signal is synchronised internally and counted as edges.

Parameters:
- GATE_CYCLES, 50_000_000: preset-gate length in Sys_CLK cycles (1 s at 50 MHz).
- TIMEOUT_CYCLES, 100_000_000: maximum wait for a signal edge in ARM or CLOSE before aborting.
- CNT_W, 32: width of num_s and num_x.

Ports:
- Sys_CLK  in  1  system clock; all logic on rising edge.
- Sys_RST  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a measurement; ignored unless state is IDLE.
- sig_in  in  1  asynchronous measured signal.
- pregate  out  1  preset gate.
- realgate  out  1  real gate, aligned to signal edges.
- busy  out  1  high whenever state is not IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- num_s  out  CNT_W  Sys_CLK cycles counted inside the real gate.
- num_x  out  CNT_W  full signal periods counted inside the real gate.
- res_err  out  1  measurement aborted by timeout.
- res_ovf  out  1  a counter saturated.

Behaviour:
- Synchroniser and edge detect:
  - sig_in passes through 2 flip-flops, s1 then s2; s3 holds the previous s2.
  - sig_rise = s2 & ~s3.
- States: IDLE, ARM, MEAS, CLOSE, DONE.
- Reset:
  - State goes to IDLE and all counters clear.
  - pregate, realgate, busy, res_valid, res_err, res_ovf go to 0; num_s and num_x go to 0.
  - Sync flops go to 0.
  - Sys_RST asserted mid-operation aborts at the next edge; no result is emitted.
- IDLE:
  - start = 1 goes to ARM.
  - The preset counter clears and pregate rises in the first ARM cycle.
  - Working counters clear.
- Preset gate: pregate stays high for exactly GATE_CYCLES cycles from ARM entry, then falls. pregate_done is asserted in the cycle pregate falls.
- ARM: sig_rise goes to MEAS. The timeout counter runs; TIMEOUT_CYCLES with no sig_rise goes to DONE with res_err = 1.
- MEAS:
  - pregate_done goes to CLOSE. The timeout counter is cleared on entry to CLOSE.
  - If the preset gate already expired in ARM, MEAS lasts exactly 1 cycle.
- CLOSE:
  - sig_rise goes to DONE.
  - Timeout goes to DONE with res_err = 1.
- realgate = (state == MEAS or state == CLOSE). It is registered, so it rises the cycle after the opening sig_rise and falls the cycle after the closing sig_rise.
- Counting:
  - num_s increments each cycle realgate = 1.
  - num_x increments on each sig_rise while realgate = 1, including the closing edge, so num_x equals whole periods.
  - Each counter saturates at all-ones and sets res_ovf.
- DONE:
  - res_valid = 1, and num_s, num_x, res_err, res_ovf are held stable.
  - The transfer completes in the cycle res_valid & res_ready. The next cycle goes to IDLE with res_valid = 0; the result outputs keep their value until the next ARM entry.
  - A sig_rise in the same cycle as pregate_done while in MEAS is counted and goes to CLOSE; it does not close the gate.
- start asserted while busy = 1 is ignored.

Optional Feature:
- Macro: DFM_AUTO_RESTART_EN.
- Defined: after a DONE handshake, go directly to ARM with counters cleared, giving continuous back-to-back measurements without start. start is still accepted in IDLE, which is reached only after reset.
- Undefined: DONE returns to IDLE; each measurement needs a start pulse.

Test Plan:
- Nominal:
  - Stimulus: GATE_CYCLES = 100; sig_in period 10 cycles, phased so sig_rise is detected at cycles ≡ 5 mod 10 after start; res_ready = 1.
  - Response: num_x = 10, num_s = 100, res_err = 0, res_ovf = 0, res_valid for 1 cycle.
- Slow signal:
  - Stimulus: GATE_CYCLES = 100, sig_in period 37.
  - Response: num_x = 3, num_s = 111 (gate extends past pregate to whole periods).
- Timeout:
  - Stimulus: sig_in held 0, TIMEOUT_CYCLES = 500.
  - Response: DONE 500 cycles after ARM entry; res_err = 1, num_x = 0, num_s = 0, realgate never high.
- Backpressure:
  - Stimulus: res_ready = 0 for 20 cycles after res_valid, plus a start pulse during DONE.
  - Response: outputs stable, start ignored, IDLE one cycle after ready.
- Reset mid-MEAS:
  - Stimulus: Sys_RST = 1 for 1 cycle during MEAS.
  - Response: next cycle state IDLE, pregate = realgate = res_valid = 0, counts = 0.
- Saturation:
  - Stimulus: CNT_W = 6, GATE_CYCLES = 100, period 10.
  - Response: num_s = 63, res_ovf = 1.
- DFM_AUTO_RESTART_EN defined:
  - Stimulus: nominal stimulus with res_ready = 1.
  - Response: second measurement starts with ARM in the cycle after the handshake; consecutive results identical.

Source files
------------

// File: rtl/dfm_meas_sequencer.sv
// Equal-precision frequency/period measurement sequencer: preset gate, signal-aligned real gate, counters, result handshake.
// Optional feature macro DFM_AUTO_RESTART_EN: re-arm straight after each accepted result instead of returning to IDLE.
module dfm_meas_sequencer #(
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 32
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  input  logic             start,
  input  logic             sig_in,
  output logic             pregate,
  output logic             realgate,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] num_s,
  output logic [CNT_W-1:0] num_x,
  output logic             res_err,
  output logic             res_ovf
);

  localparam int PW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, ARM, MEAS, CLOSE, DONE} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic          sig_rise;
  logic [PW-1:0] pre_cnt;
  logic          gate_expired;
  logic [TW-1:0] to_cnt;
  logic          arm_now;

  assign sig_rise = s2 & ~s3;

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Entry into ARM happens from IDLE on start, or from an accepted DONE when auto-restart is built in.
  always_comb begin
    arm_now = (state == IDLE) && start;
`ifdef DFM_AUTO_RESTART_EN
    if ((state == DONE) && res_ready) arm_now = 1'b1;
`endif
  end

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      state        <= IDLE;
      pregate      <= 1'b0;
      realgate     <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_err      <= 1'b0;
      res_ovf      <= 1'b0;
      num_s        <= '0;
      num_x        <= '0;
      pre_cnt      <= '0;
      gate_expired <= 1'b0;
      to_cnt       <= '0;
    end else begin
      if (pregate) begin
        if (pre_cnt == PRE_LAST) begin
          pregate      <= 1'b0;
          gate_expired <= 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end

      if (realgate) begin
        if (num_s == CNT_MAX) res_ovf <= 1'b1;
        else                  num_s   <= num_s + 1'b1;
        if (sig_rise) begin
          if (num_x == CNT_MAX) res_ovf <= 1'b1;
          else                  num_x   <= num_x + 1'b1;
        end
      end

      case (state)
        IDLE: ;
        ARM: begin
          if (sig_rise) begin
            state    <= MEAS;
            realgate <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state     <= DONE;
            pregate   <= 1'b0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // A signal edge coinciding with the gate expiry is counted but never closes the gate here.
        MEAS: begin
          if (gate_expired) begin
            state  <= CLOSE;
            to_cnt <= '0;
          end
        end
        CLOSE: begin
          if (sig_rise) begin
            state     <= DONE;
            realgate  <= 1'b0;
            res_valid <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state     <= DONE;
            realgate  <= 1'b0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (arm_now) begin
        state        <= ARM;
        busy         <= 1'b1;
        pregate      <= 1'b1;
        realgate     <= 1'b0;
        pre_cnt      <= '0;
        gate_expired <= 1'b0;
        to_cnt       <= '0;
        num_s        <= '0;
        num_x        <= '0;
        res_err      <= 1'b0;
        res_ovf      <= 1'b0;
      end
    end
  end

endmodule
